// File: rtl/bypass_scoreboard_pkg.sv
// Shared definitions for the issue-stage bypass/interlock unit: default sizes,
// the per-source lookup outcome, and an index-width helper.
package bypass_scoreboard_pkg;

    localparam int DEF_ISSUE_W = 2;
    localparam int DEF_NSTAGE  = 4;
    localparam int DEF_NSRC    = 2;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_REG_AW  = 5;

    typedef enum logic [1:0] {
        SRC_RF  = 2'd0,
        SRC_FWD = 2'd1,
        SRC_HAZ = 2'd2
    } src_sel_e;

    // Index width that stays at least one bit wide for single-entry dimensions.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bypass_match.sv
// Compares one source register against every tracked writer and reports the
// highest-priority hit (youngest stage, then youngest lane) and its readiness.
module bypass_match
    import bypass_scoreboard_pkg::*;
#(
    parameter int NSTAGE  = DEF_NSTAGE,
    parameter int ISSUE_W = DEF_ISSUE_W,
    parameter int REG_AW  = DEF_REG_AW,
    parameter int RDY_W   = $clog2(DEF_NSTAGE + 1),
    parameter int STG_W   = idx_w(DEF_NSTAGE),
    parameter int LANE_W  = idx_w(DEF_ISSUE_W)
) (
    input  logic [REG_AW-1:0]                src,
    input  logic [NSTAGE*ISSUE_W-1:0]        ent_valid,
    input  logic [NSTAGE*ISSUE_W*REG_AW-1:0] ent_rdst,
    input  logic [NSTAGE*ISSUE_W*RDY_W-1:0]  ent_rdy,
    output src_sel_e                         sel,
    output logic [STG_W-1:0]                 hit_stage,
    output logic [LANE_W-1:0]                hit_lane
);

    // Scan oldest-to-youngest so the last match written holds the priority winner.
    always_comb begin
        sel       = SRC_RF;
        hit_stage = '0;
        hit_lane  = '0;
        if (src != '0) begin
            for (int k = NSTAGE - 1; k >= 0; k--) begin
                for (int l = 0; l < ISSUE_W; l++) begin
                    if (ent_valid[k*ISSUE_W + l] &&
                        ent_rdst[(k*ISSUE_W + l)*REG_AW +: REG_AW] == src) begin
                        sel       = (ent_rdy[(k*ISSUE_W + l)*RDY_W +: RDY_W] <= RDY_W'(k))
                                    ? SRC_FWD : SRC_HAZ;
                        hit_stage = STG_W'(k);
                        hit_lane  = LANE_W'(l);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/bypass_scoreboard.sv
// Forwarding and interlock unit for the in-order issue stage: tracks in-flight
// writers per stage/lane, resolves operands, and raises split/stall requests.
module bypass_scoreboard
    import bypass_scoreboard_pkg::*;
#(
    parameter int ISSUE_W = DEF_ISSUE_W,
    parameter int NSTAGE  = DEF_NSTAGE,
    parameter int NSRC    = DEF_NSRC,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int REG_AW  = DEF_REG_AW,
    localparam int RDY_W  = $clog2(NSTAGE + 1)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              stall_i,
    input  logic [NSTAGE-1:0]                 kill_i,
    input  logic [ISSUE_W-1:0]                iss_valid_i,
    input  logic [ISSUE_W-1:0]                iss_wr_i,
    input  logic [ISSUE_W*REG_AW-1:0]         iss_rdst_i,
    input  logic [ISSUE_W*RDY_W-1:0]          iss_rdy_i,
    input  logic [ISSUE_W*NSRC*REG_AW-1:0]    iss_src_i,
    input  logic [ISSUE_W*NSRC*DATA_W-1:0]    rf_data_i,
    input  logic [NSTAGE*ISSUE_W*DATA_W-1:0]  stg_data_i,
    output logic [ISSUE_W*NSRC*DATA_W-1:0]    src_data_o,
    output logic [ISSUE_W*NSRC-1:0]           src_fwd_o,
    output logic                              stall_req_o,
    output logic [ISSUE_W-1:0]                split_o,
    output logic [31:0]                       stall_cnt_o
);

    localparam int STG_W  = idx_w(NSTAGE);
    localparam int LANE_W = idx_w(ISSUE_W);
    localparam int NLOOK  = ISSUE_W * NSRC;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rdst;
        logic [RDY_W-1:0]  rdy;
    } byp_entry_t;

    byp_entry_t ent_q [NSTAGE][ISSUE_W];

    logic [NSTAGE*ISSUE_W-1:0]        ent_valid;
    logic [NSTAGE*ISSUE_W*REG_AW-1:0] ent_rdst;
    logic [NSTAGE*ISSUE_W*RDY_W-1:0]  ent_rdy;

    src_sel_e          sel       [NLOOK];
    logic [STG_W-1:0]  hit_stage [NLOOK];
    logic [LANE_W-1:0] hit_lane  [NLOOK];

    for (genvar k = 0; k < NSTAGE; k++) begin : g_flat_stage
        for (genvar l = 0; l < ISSUE_W; l++) begin : g_flat_lane
            assign ent_valid[k*ISSUE_W + l]                      = ent_q[k][l].valid;
            assign ent_rdst[(k*ISSUE_W + l)*REG_AW +: REG_AW]    = ent_q[k][l].rdst;
            assign ent_rdy[(k*ISSUE_W + l)*RDY_W +: RDY_W]       = ent_q[k][l].rdy;
        end
    end

    for (genvar g = 0; g < NLOOK; g++) begin : g_match
        bypass_match #(
            .NSTAGE  (NSTAGE),
            .ISSUE_W (ISSUE_W),
            .REG_AW  (REG_AW),
            .RDY_W   (RDY_W),
            .STG_W   (STG_W),
            .LANE_W  (LANE_W)
        ) u_match (
            .src       (iss_src_i[g*REG_AW +: REG_AW]),
            .ent_valid (ent_valid),
            .ent_rdst  (ent_rdst),
            .ent_rdy   (ent_rdy),
            .sel       (sel[g]),
            .hit_stage (hit_stage[g]),
            .hit_lane  (hit_lane[g])
        );
    end

    always_comb begin
        int idx;
        idx        = 0;
        src_data_o = rf_data_i;
        src_fwd_o  = '0;
        for (int g = 0; g < NLOOK; g++) begin
            if (sel[g] == SRC_FWD) begin
                idx                              = int'(hit_stage[g]) * ISSUE_W + int'(hit_lane[g]);
                src_fwd_o[g]                     = 1'b1;
                src_data_o[g*DATA_W +: DATA_W]   = stg_data_i[idx*DATA_W +: DATA_W];
            end
        end
    end

    // Once any lane must hold, every younger lane holds with it to keep issue in order.
    always_comb begin
        logic chain;
        logic hz;
        logic dep;
        chain   = 1'b0;
        split_o = '0;
        for (int j = 0; j < ISSUE_W; j++) begin
            hz  = 1'b0;
            dep = 1'b0;
            for (int s = 0; s < NSRC; s++) begin
                if (sel[j*NSRC + s] == SRC_HAZ)
                    hz = 1'b1;
                for (int i = 0; i < j; i++) begin
                    if (iss_valid_i[i] && iss_wr_i[i] &&
                        iss_rdst_i[i*REG_AW +: REG_AW] != '0 &&
                        iss_src_i[(j*NSRC + s)*REG_AW +: REG_AW] == iss_rdst_i[i*REG_AW +: REG_AW])
                        dep = 1'b1;
                end
            end
            chain      = chain | (iss_valid_i[j] & (hz | dep));
            split_o[j] = chain;
        end
    end

    assign stall_req_o = split_o[0];

    // Killed entries are dropped rather than shifted; a hold still honours kills in place.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NSTAGE; k++)
                for (int l = 0; l < ISSUE_W; l++)
                    ent_q[k][l] <= '0;
            stall_cnt_o <= '0;
        end else begin
            if (!stall_i) begin
                for (int l = 0; l < ISSUE_W; l++) begin
                    ent_q[0][l].valid <= iss_valid_i[l] & iss_wr_i[l] & ~split_o[l] &
                                         (iss_rdst_i[l*REG_AW +: REG_AW] != '0);
                    ent_q[0][l].rdst  <= iss_rdst_i[l*REG_AW +: REG_AW];
                    ent_q[0][l].rdy   <= iss_rdy_i[l*RDY_W +: RDY_W];
                end
                for (int k = 1; k < NSTAGE; k++)
                    for (int l = 0; l < ISSUE_W; l++)
                        ent_q[k][l] <= kill_i[k-1] ? '0 : ent_q[k-1][l];
            end else begin
                for (int k = 0; k < NSTAGE; k++)
                    for (int l = 0; l < ISSUE_W; l++)
                        if (kill_i[k])
                            ent_q[k][l].valid <= 1'b0;
            end
            if (stall_req_o && !stall_i && stall_cnt_o != 32'hFFFF_FFFF)
                stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end

endmodule

// File: tb/tb_bypass_scoreboard.sv
// Scoreboard bench for bypass_scoreboard: a queue-of-writers reference model
// predicts each cycle's outputs, and a negedge monitor checks them.
module tb_bypass_scoreboard;

    localparam int ISSUE_W = 2;
    localparam int NSTAGE  = 4;
    localparam int NSRC    = 2;
    localparam int DATA_W  = 32;
    localparam int REG_AW  = 5;
    localparam int RDY_W   = 3;
    localparam int NS      = ISSUE_W * NSRC;

    logic                             clk = 1'b0;
    logic                             reset;
    logic                             stall_i;
    logic [NSTAGE-1:0]                kill_i;
    logic [ISSUE_W-1:0]               iss_valid_i;
    logic [ISSUE_W-1:0]               iss_wr_i;
    logic [ISSUE_W*REG_AW-1:0]        iss_rdst_i;
    logic [ISSUE_W*RDY_W-1:0]         iss_rdy_i;
    logic [NS*REG_AW-1:0]             iss_src_i;
    logic [NS*DATA_W-1:0]             rf_data_i;
    logic [NSTAGE*ISSUE_W*DATA_W-1:0] stg_data_i;
    logic [NS*DATA_W-1:0]             src_data_o;
    logic [NS-1:0]                    src_fwd_o;
    logic                             stall_req_o;
    logic [ISSUE_W-1:0]               split_o;
    logic [31:0]                      stall_cnt_o;

    bypass_scoreboard #(
        .ISSUE_W (ISSUE_W),
        .NSTAGE  (NSTAGE),
        .NSRC    (NSRC),
        .DATA_W  (DATA_W),
        .REG_AW  (REG_AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall_i     (stall_i),
        .kill_i      (kill_i),
        .iss_valid_i (iss_valid_i),
        .iss_wr_i    (iss_wr_i),
        .iss_rdst_i  (iss_rdst_i),
        .iss_rdy_i   (iss_rdy_i),
        .iss_src_i   (iss_src_i),
        .rf_data_i   (rf_data_i),
        .stg_data_i  (stg_data_i),
        .src_data_o  (src_data_o),
        .src_fwd_o   (src_fwd_o),
        .stall_req_o (stall_req_o),
        .split_o     (split_o),
        .stall_cnt_o (stall_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rd;
        int rdy;
        int age;
        int lane;
    } wr_t;

    typedef struct {
        logic [NS*DATA_W-1:0] data;
        logic [NS-1:0]        fwd;
        logic [NS-1:0]        data_chk;
        logic [ISSUE_W-1:0]   split;
        logic                 stall_req;
        logic [31:0]          cnt;
        int                   cyc;
    } exp_t;

    wr_t   inflight[$];
    exp_t  sb[$];
    longint cnt_model = 0;
    int    cyc = 0;
    int    tests = 0;
    int    fails = 0;

    // Youngest stage wins, then the higher lane; kind 0=regfile, 1=forward, 2=hazard.
    function automatic void lookup(input int src, output int kind, output int age, output int lane);
        int best = -1;
        kind = 0; age = 0; lane = 0;
        if (src == 0) return;
        foreach (inflight[i]) begin
            if (inflight[i].rd == src) begin
                if (best < 0 || inflight[i].age < inflight[best].age ||
                    (inflight[i].age == inflight[best].age && inflight[i].lane > inflight[best].lane))
                    best = i;
            end
        end
        if (best >= 0) begin
            age  = inflight[best].age;
            lane = inflight[best].lane;
            kind = (inflight[best].rdy <= age) ? 1 : 2;
        end
    endfunction

    task automatic clear_inputs();
        stall_i     = 1'b0;
        kill_i      = '0;
        iss_valid_i = '0;
        iss_wr_i    = '0;
        iss_rdst_i  = '0;
        iss_rdy_i   = '0;
        iss_src_i   = '0;
        rf_data_i   = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < NSTAGE * ISSUE_W; i++)
            stg_data_i[i*DATA_W +: DATA_W] = $urandom;
    endtask

    task automatic set_issue(input int l, input int rd, input int rdy);
        iss_valid_i[l]                 = 1'b1;
        iss_wr_i[l]                    = 1'b1;
        iss_rdst_i[l*REG_AW +: REG_AW] = REG_AW'(rd);
        iss_rdy_i[l*RDY_W +: RDY_W]    = RDY_W'(rdy);
    endtask

    task automatic set_src(input int l, input int s, input int rd);
        iss_valid_i[l]                             = 1'b1;
        iss_src_i[(l*NSRC + s)*REG_AW +: REG_AW]   = REG_AW'(rd);
    endtask

    // Predicts this cycle's outputs, queues them, then advances the model across the edge.
    task automatic apply_stimulus();
        exp_t e;
        wr_t  nq[$];
        wr_t  w;
        int   kind_a[NS];
        int   kind, age, lane, src, rdi;
        bit   chain, hz, dep;
        cyc++;
        if (reset) begin
            inflight.delete();
            cnt_model = 0;
        end else begin
            e.cyc = cyc;
            e.data = '0; e.fwd = '0; e.data_chk = '0; e.split = '0;
            for (int g = 0; g < NS; g++) begin
                src = int'(iss_src_i[g*REG_AW +: REG_AW]);
                lookup(src, kind, age, lane);
                kind_a[g]     = kind;
                e.fwd[g]      = (kind == 1);
                e.data_chk[g] = (kind != 2);
                e.data[g*DATA_W +: DATA_W] = (kind == 1)
                    ? stg_data_i[(age*ISSUE_W + lane)*DATA_W +: DATA_W]
                    : rf_data_i[g*DATA_W +: DATA_W];
            end
            chain = 0;
            for (int j = 0; j < ISSUE_W; j++) begin
                hz = 0; dep = 0;
                for (int s = 0; s < NSRC; s++) begin
                    if (kind_a[j*NSRC + s] == 2) hz = 1;
                    src = int'(iss_src_i[(j*NSRC + s)*REG_AW +: REG_AW]);
                    for (int i = 0; i < j; i++) begin
                        rdi = int'(iss_rdst_i[i*REG_AW +: REG_AW]);
                        if (iss_valid_i[i] && iss_wr_i[i] && rdi != 0 && src == rdi) dep = 1;
                    end
                end
                if (iss_valid_i[j] && (hz || dep)) chain = 1;
                e.split[j] = chain;
            end
            e.stall_req = e.split[0];
            e.cnt       = 32'(cnt_model);
            sb.push_back(e);

            foreach (inflight[i]) begin
                w = inflight[i];
                if (stall_i) begin
                    if (!kill_i[w.age]) nq.push_back(w);
                end else if (!kill_i[w.age] && w.age + 1 < NSTAGE) begin
                    w.age++;
                    nq.push_back(w);
                end
            end
            if (!stall_i) begin
                for (int l = 0; l < ISSUE_W; l++) begin
                    rdi = int'(iss_rdst_i[l*REG_AW +: REG_AW]);
                    if (iss_valid_i[l] && iss_wr_i[l] && rdi != 0 && !e.split[l]) begin
                        w.rd = rdi; w.rdy = int'(iss_rdy_i[l*RDY_W +: RDY_W]); w.age = 0; w.lane = l;
                        nq.push_back(w);
                    end
                end
            end
            inflight = nq;
            if (e.stall_req && !stall_i && cnt_model < 64'hFFFF_FFFF) cnt_model++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input exp_t e);
        tests++;
        if (split_o !== e.split) begin
            fails++;
            $display("[TB] FAIL cyc %0d split_o: got %b want %b", e.cyc, split_o, e.split);
        end
        tests++;
        if (stall_req_o !== e.stall_req) begin
            fails++;
            $display("[TB] FAIL cyc %0d stall_req_o: got %b want %b", e.cyc, stall_req_o, e.stall_req);
        end
        tests++;
        if (stall_cnt_o !== e.cnt) begin
            fails++;
            $display("[TB] FAIL cyc %0d stall_cnt_o: got %0d want %0d", e.cyc, stall_cnt_o, e.cnt);
        end
        tests++;
        if (src_fwd_o !== e.fwd) begin
            fails++;
            $display("[TB] FAIL cyc %0d src_fwd_o: got %b want %b", e.cyc, src_fwd_o, e.fwd);
        end
        for (int g = 0; g < NS; g++) begin
            if (e.data_chk[g]) begin
                tests++;
                if (src_data_o[g*DATA_W +: DATA_W] !== e.data[g*DATA_W +: DATA_W]) begin
                    fails++;
                    $display("[TB] FAIL cyc %0d src_data[%0d]: got %h want %h", e.cyc, g,
                             src_data_o[g*DATA_W +: DATA_W], e.data[g*DATA_W +: DATA_W]);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) check_output(sb.pop_front());
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        clear_inputs();
        @(posedge clk); #1;
        apply_stimulus();
        reset = 1'b0;

        // ALU chain
        clear_inputs(); set_issue(0, 3, 0); apply_stimulus();
        clear_inputs(); set_src(0, 0, 3); stg_data_i[DATA_W-1:0] = 32'h1234; apply_stimulus();

        // Load-use interlock for two cycles, then forward from stage 2
        clear_inputs(); set_issue(0, 5, 2); apply_stimulus();
        for (int i = 0; i < 3; i++) begin
            clear_inputs(); set_src(0, 0, 5); apply_stimulus();
        end
        clear_inputs(); apply_stimulus();

        // Same-stage conflict: younger lane wins, older stage ignored
        clear_inputs(); set_issue(0, 7, 0); apply_stimulus();
        clear_inputs(); set_issue(0, 7, 0); set_issue(1, 7, 0); apply_stimulus();
        clear_inputs(); set_src(0, 1, 7);
        stg_data_i[0*DATA_W +: DATA_W] = 32'd1; stg_data_i[1*DATA_W +: DATA_W] = 32'd2;
        apply_stimulus();

        // Intra-group dependency
        clear_inputs(); set_issue(0, 4, 0); set_src(1, 0, 4); apply_stimulus();
        clear_inputs(); set_src(0, 0, 4); apply_stimulus();

        // Kill of a stage-1 writer, and r0 never forwarded
        clear_inputs(); set_issue(0, 9, 0); apply_stimulus();
        clear_inputs(); apply_stimulus();
        clear_inputs(); kill_i = 4'b0010; apply_stimulus();
        clear_inputs(); set_src(0, 0, 9); set_issue(1, 0, 0); apply_stimulus();
        clear_inputs(); set_src(0, 0, 0); set_src(1, 1, 0); apply_stimulus();

        // Reset while a load-use hazard is pending
        clear_inputs(); set_issue(0, 5, 2); apply_stimulus();
        clear_inputs(); set_src(0, 0, 5); apply_stimulus();
        reset = 1'b1; clear_inputs(); set_src(0, 0, 5); apply_stimulus();
        reset = 1'b0; clear_inputs(); set_src(0, 0, 5); apply_stimulus();

        for (int n = 0; n < 400; n++) begin
            clear_inputs();
            iss_valid_i = ISSUE_W'($urandom);
            iss_wr_i    = ISSUE_W'($urandom);
            for (int l = 0; l < ISSUE_W; l++) begin
                iss_rdst_i[l*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 7));
                iss_rdy_i[l*RDY_W +: RDY_W]    = RDY_W'($urandom_range(0, NSTAGE));
            end
            for (int g = 0; g < NS; g++)
                iss_src_i[g*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 7));
            stall_i = ($urandom_range(0, 7) == 0);
            for (int k = 0; k < NSTAGE; k++)
                kill_i[k] = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 99) == 0);
            apply_stimulus();
        end
        reset = 1'b0;

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
